// File: rtl/mux_select_scheduler_if.sv
// Handshake bundle between the line-buffer window, the mux-select scheduler
// and the selection/compute stages downstream.
`timescale 1ns/1ps
interface mux_select_scheduler_if #(
    parameter int SEL_W = 1
);
    logic             window_valid;
    logic             window_ready;
    logic             mux_enable;
    logic [SEL_W-1:0] mux_select;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;

    modport master (
        input  window_valid,
        input  out_ready,
        output window_ready,
        output mux_enable,
        output mux_select,
        output out_valid,
        output out_last
    );

    modport slave (
        output window_valid,
        output out_ready,
        input  window_ready,
        input  mux_enable,
        input  mux_select,
        input  out_valid,
        input  out_last
    );
endinterface

// File: rtl/mux_select_scheduler.sv
// Issues the NUM_INPUT feature-map groups of each sliding window to the selection stage.
// Optional MUX_SCHED_WIN_CNT_EN adds a 16-bit count of completed windows (win_count).
`timescale 1ns/1ps
module mux_select_scheduler #(
    parameter int Nin       = 3,
    parameter int Pin       = 2,
    parameter int NUM_INPUT = (Nin + Pin - 1) / Pin
) (
    input  logic                  clk,
    input  logic                  rst,
    mux_select_scheduler_if.master bus
`ifdef MUX_SCHED_WIN_CNT_EN
    ,
    output logic [15:0]           win_count
`endif
);

  localparam int SEL_W = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state_reg;
  logic [SEL_W-1:0] grp_reg;
  logic             out_valid_reg;
  logic             out_last_reg;

  logic slot_free;
  logic grp_last;
  logic mux_enable_c;
  logic window_ready_c;

  // At grp 0 a new window is being entered, so issue only while one is presented.
  always_comb begin
    slot_free      = !out_valid_reg || bus.out_ready;
    grp_last       = (grp_reg == SEL_W'(NUM_INPUT - 1));
    mux_enable_c   = !rst && (state_reg == ISSUE) && slot_free &&
                     ((grp_reg != '0) || bus.window_valid);
    window_ready_c = mux_enable_c && grp_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      grp_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          grp_reg <= '0;
          if (bus.window_valid) begin
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (mux_enable_c) begin
            grp_reg <= grp_last ? '0 : grp_reg + SEL_W'(1);
          end else if ((grp_reg == '0) && !bus.window_valid) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      if (mux_enable_c) begin
        out_valid_reg <= 1'b1;
        out_last_reg  <= grp_last;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end
  end

  assign bus.mux_enable   = mux_enable_c;
  assign bus.window_ready = window_ready_c;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_last     = out_last_reg;

  generate
    if (NUM_INPUT == 1) begin : g_single_group
      assign bus.mux_select = '0;
    end else begin : g_multi_group
      assign bus.mux_select = rst ? '0 : grp_reg;
    end
  endgenerate

`ifdef MUX_SCHED_WIN_CNT_EN
  logic [15:0] win_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_count_reg <= '0;
    end else if (window_ready_c) begin
      win_count_reg <= win_count_reg + 16'd1;
    end
  end

  assign win_count = win_count_reg;
`endif

endmodule

// File: tb/tb_mux_select_scheduler.sv
// Scoreboard bench: three scheduler configurations (2, 1 and 4 groups per window)
// driven with directed windows; a monitor per instance checks every output transfer.
`timescale 1ns/1ps
module tb_mux_select_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_select_scheduler_if #(.SEL_W(1)) a_if ();
  mux_select_scheduler_if #(.SEL_W(1)) b_if ();
  mux_select_scheduler_if #(.SEL_W(2)) c_if ();

`ifdef MUX_SCHED_WIN_CNT_EN
  logic [15:0] a_wc, b_wc, c_wc;
`endif

  mux_select_scheduler #(.Nin(3), .Pin(2)) dut_a (
      .clk(clk), .rst(rst), .bus(a_if)
`ifdef MUX_SCHED_WIN_CNT_EN
      , .win_count(a_wc)
`endif
  );
  mux_select_scheduler #(.Nin(4), .Pin(4)) dut_b (
      .clk(clk), .rst(rst), .bus(b_if)
`ifdef MUX_SCHED_WIN_CNT_EN
      , .win_count(b_wc)
`endif
  );
  mux_select_scheduler #(.Nin(7), .Pin(2)) dut_c (
      .clk(clk), .rst(rst), .bus(c_if)
`ifdef MUX_SCHED_WIN_CNT_EN
      , .win_count(c_wc)
`endif
  );

  typedef struct {int sel; int last;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int n_cmp = 0;
  int n_fail = 0;
  int a_wr = 0, b_wr = 0, c_wr = 0;
  int a_data = 0, b_data = 0, c_data = 0;
  bit quiet = 1'b0;
  exp_t ea, eb, ec;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int s, input int l);
    exp_t e;
    e.sel  = s;
    e.last = l;
    return e;
  endfunction

  // Monitors: sample late in the low phase, after stimulus for the cycle has settled.
  always @(negedge clk) begin
    #2;
    if (a_if.out_valid === 1'b1 && a_if.out_ready === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL A.xfer: got an unrequested transfer, expected none");
      end else begin
        ea = qa.pop_front();
        chk("A.sel", a_data, ea.sel);
        chk("A.last", a_if.out_last, ea.last);
        if (!quiet) $display("A xfer sel=%0d last=%0d", a_data, a_if.out_last);
      end
    end
    if (a_if.mux_enable === 1'b1) a_data = a_if.mux_select;
    if (a_if.window_ready === 1'b1) a_wr++;
  end

  always @(negedge clk) begin
    #2;
    if (b_if.out_valid === 1'b1 && b_if.out_ready === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL B.xfer: got an unrequested transfer, expected none");
      end else begin
        eb = qb.pop_front();
        chk("B.sel", b_data, eb.sel);
        chk("B.last", b_if.out_last, eb.last);
        if (!quiet) $display("B xfer sel=%0d last=%0d", b_data, b_if.out_last);
      end
    end
    if (b_if.mux_enable === 1'b1) b_data = b_if.mux_select;
    if (b_if.window_ready === 1'b1) b_wr++;
  end

  always @(negedge clk) begin
    #2;
    if (c_if.out_valid === 1'b1 && c_if.out_ready === 1'b1) begin
      if (qc.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL C.xfer: got an unrequested transfer, expected none");
      end else begin
        ec = qc.pop_front();
        chk("C.sel", c_data, ec.sel);
        chk("C.last", c_if.out_last, ec.last);
        if (!quiet) $display("C xfer sel=%0d last=%0d", c_data, c_if.out_last);
      end
    end
    if (c_if.mux_enable === 1'b1) c_data = c_if.mux_select;
    if (c_if.window_ready === 1'b1) c_wr++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_exp_wr;
    b_exp_wr = 5;
    a_if.window_valid = 0; a_if.out_ready = 1;
    b_if.window_valid = 0; b_if.out_ready = 1;
    c_if.window_valid = 0; c_if.out_ready = 1;
    rst = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("RST.a_out_valid", a_if.out_valid, 0);
    chk("RST.a_out_last", a_if.out_last, 0);
    chk("RST.a_enable", a_if.mux_enable, 0);
    chk("RST.a_window_ready", a_if.window_ready, 0);
    chk("RST.c_select", c_if.mux_select, 0);
    chk("RST.c_out_valid", c_if.out_valid, 0);
    rst = 0;

    // Back-to-back windows, two groups each.
    @(negedge clk); a_if.window_valid = 1; #1;
    chk("T1.idle_enable", a_if.mux_enable, 0);
    qa.push_back(mk(0, 0)); qa.push_back(mk(1, 1));
    qa.push_back(mk(0, 0)); qa.push_back(mk(1, 1));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      chk("T1.enable", a_if.mux_enable, 1);
      chk("T1.select", a_if.mux_select, (k - 1) % 2);
      chk("T1.window_ready", a_if.window_ready, (k % 2 == 0) ? 1 : 0);
    end
    @(negedge clk); a_if.window_valid = 0; #1;
    chk("T1.end_enable", a_if.mux_enable, 0);
    repeat (2) @(negedge clk);

    // Downstream stall right after the first issue.
    @(negedge clk); a_if.window_valid = 1;
    qa.push_back(mk(0, 0)); qa.push_back(mk(1, 1));
    @(negedge clk); #1;
    chk("T2.first_enable", a_if.mux_enable, 1);
    chk("T2.first_select", a_if.mux_select, 0);
    a_if.out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("T2.stall_enable", a_if.mux_enable, 0);
      chk("T2.stall_select", a_if.mux_select, 1);
      chk("T2.stall_out_valid", a_if.out_valid, 1);
    end
    a_if.out_ready = 1; #1;
    chk("T2.resume_enable", a_if.mux_enable, 1);
    chk("T2.resume_select", a_if.mux_select, 1);
    chk("T2.resume_window_ready", a_if.window_ready, 1);
    @(negedge clk); a_if.window_valid = 0; #1;
    chk("T2.end_enable", a_if.mux_enable, 0);
    repeat (2) @(negedge clk);

    // window_valid drops after the first group; the window still completes.
    @(negedge clk); a_if.window_valid = 1;
    qa.push_back(mk(0, 0)); qa.push_back(mk(1, 1));
    @(negedge clk); #1;
    chk("T3.enable0", a_if.mux_enable, 1);
    chk("T3.select0", a_if.mux_select, 0);
    @(negedge clk); a_if.window_valid = 0; #1;
    chk("T3.enable1", a_if.mux_enable, 1);
    chk("T3.select1", a_if.mux_select, 1);
    chk("T3.window_ready", a_if.window_ready, 1);
    @(negedge clk); #1;
    chk("T3.after_enable", a_if.mux_enable, 0);
    @(negedge clk); #1;
    chk("T3.idle_enable", a_if.mux_enable, 0);
    repeat (2) @(negedge clk);

    // Single group per window: five windows back to back.
    @(negedge clk); b_if.window_valid = 1; #1;
    chk("T4.idle_enable", b_if.mux_enable, 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); #1;
      chk("T4.enable", b_if.mux_enable, 1);
      chk("T4.select", b_if.mux_select, 0);
      chk("T4.window_ready", b_if.window_ready, 1);
      qb.push_back(mk(0, 1));
    end
    @(negedge clk); b_if.window_valid = 0; #1;
    chk("T4.end_enable", b_if.mux_enable, 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a four-group window, then a fresh window.
    @(negedge clk); c_if.window_valid = 1;
    qc.push_back(mk(0, 0)); qc.push_back(mk(1, 0));
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      chk("T5.enable", c_if.mux_enable, 1);
      chk("T5.select", c_if.mux_select, k - 1);
    end
    rst = 1; #1;
    chk("T5.rst_enable", c_if.mux_enable, 0);
    chk("T5.rst_window_ready", c_if.window_ready, 0);
    chk("T5.rst_select", c_if.mux_select, 0);
    @(negedge clk); #1;
    chk("T5.rst_out_valid", c_if.out_valid, 0);
    chk("T5.rst_out_last", c_if.out_last, 0);
    rst = 0; #1;
    chk("T5.idle_enable", c_if.mux_enable, 0);
    chk("T5.idle_select", c_if.mux_select, 0);
    qc.push_back(mk(0, 0)); qc.push_back(mk(1, 0));
    qc.push_back(mk(2, 0)); qc.push_back(mk(3, 1));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      chk("T5.re_enable", c_if.mux_enable, 1);
      chk("T5.re_select", c_if.mux_select, k - 1);
      chk("T5.re_window_ready", c_if.window_ready, (k == 4) ? 1 : 0);
    end
    @(negedge clk); c_if.window_valid = 0; #1;
    chk("T5.end_enable", c_if.mux_enable, 0);
    repeat (3) @(negedge clk);

`ifdef MUX_SCHED_WIN_CNT_EN
    // Drive the window counter to 0xFFFF, then one more window wraps it.
    quiet = 1'b1;
    @(negedge clk); b_if.window_valid = 1;
    for (int i = 1; i <= 65530; i++) begin
      @(negedge clk);
      qb.push_back(mk(0, 1));
    end
    @(negedge clk); b_if.window_valid = 0; #1;
    chk("T6.win_count_max", b_wc, 16'hFFFF);
    @(negedge clk); b_if.window_valid = 1;
    @(negedge clk); #1;
    chk("T6.enable", b_if.mux_enable, 1);
    qb.push_back(mk(0, 1));
    @(negedge clk); b_if.window_valid = 0; #1;
    chk("T6.win_count_wrap", b_wc, 0);
    repeat (3) @(negedge clk);
    quiet = 1'b0;
    b_exp_wr = 5 + 65531;
    chk("T6.a_win_count", a_wc, 4);
    chk("T6.c_win_count", c_wc, 1);
`endif

    #3;
    chk("END.qa_empty", qa.size(), 0);
    chk("END.qb_empty", qb.size(), 0);
    chk("END.qc_empty", qc.size(), 0);
    chk("END.a_window_ready_count", a_wr, 4);
    chk("END.b_window_ready_count", b_wr, b_exp_wr);
    chk("END.c_window_ready_count", c_wr, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_select_scheduler.md
MUX_SELECT_SCHEDULER -- requirements
Module: mux_select_scheduler

Interface
REQ-001 SHALL have parameter Nin, default 3: number of input feature maps presented by the line buffers.
REQ-002 SHALL have parameter Pin, default 2: number of feature maps issued per cycle to the selection stage.
REQ-003 SHALL have parameter NUM_INPUT, default ceil_div(Nin, Pin): number of groups per window; not overridden by users.
REQ-004 SHALL have port clk, input, 1 bit: system clock; the block uses one clock and all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port window_valid, input, 1 bit: the line-buffer sliding window is stable and valid.
REQ-007 SHALL have port window_ready, output, 1 bit: one-cycle pulse that releases the current window so the line buffer may advance.
REQ-008 SHALL have port mux_enable, output, 1 bit: load enable for the selection-stage output register.
REQ-009 SHALL have port mux_select, output, clog2(NUM_INPUT) bits: group index applied to the selection stage.
REQ-010 SHALL have port out_valid, output, 1 bit: the selection-stage output register holds valid data.
REQ-011 SHALL have port out_last, output, 1 bit: the valid data is the last group (NUM_INPUT-1) of its window.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream compute stage accepts data this cycle.

Function
REQ-013 SHALL implement a two-state FSM with states IDLE and ISSUE.
REQ-014 In IDLE with window_valid=1, the FSM SHALL move to ISSUE on the next edge with the group counter grp=0.
REQ-015 In ISSUE, the signal "slot free" SHALL equal (!out_valid || out_ready).
REQ-016 In ISSUE, mux_enable SHALL equal "slot free" combinationally, and mux_select SHALL equal grp.
REQ-017 mux_enable SHALL be 0 in IDLE.
REQ-018 On each cycle with mux_enable=1, grp SHALL increment.
REQ-019 On a mux_enable cycle with grp==NUM_INPUT-1: window_ready SHALL pulse 1 in the same cycle, and grp SHALL wrap to 0.
REQ-020 After a window_ready pulse: if window_valid is still 1 in the following cycle, the FSM SHALL stay in ISSUE; otherwise it SHALL return to IDLE. No idle bubble is inserted between back-to-back windows.
REQ-021 window_valid SHALL be sampled only while grp==0 and the FSM is in IDLE or ISSUE entry. If window_valid drops mid-window, the window SHALL still complete its remaining groups.
REQ-022 out_valid SHALL be registered: set to 1 on a mux_enable cycle, and cleared when out_ready=1 without mux_enable. The data latency from mux_enable to out_valid is exactly 1 cycle.
REQ-023 out_last SHALL be registered alongside out_valid, equal to (grp==NUM_INPUT-1) at the enable cycle, and held while out_valid=1 and out_ready=0.
REQ-024 When out_valid=1 and out_ready=0 (stall), mux_enable SHALL be 0, and grp, out_valid and out_last SHALL hold.
REQ-025 When NUM_INPUT==1: mux_select SHALL be 1 bit tied to 0, every issue SHALL be last, and window_ready SHALL pulse on every enable.
REQ-026 Sustained throughput SHALL be one group per cycle while out_ready=1 and windows are available.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, grp=0, out_valid=0, out_last=0. Combinational outputs SHALL read mux_enable=0, window_ready=0 and mux_select=0 during reset.
REQ-028 rst SHALL take priority over all other inputs; a window in flight SHALL be abandoned without a window_ready pulse.

Configuration
REQ-029 Macro MUX_SCHED_WIN_CNT_EN: when defined, the block SHALL add output win_count, 16 bits. win_count SHALL reset to 0, increment on each window_ready pulse, and wrap from 0xFFFF to 0.
REQ-030 Without MUX_SCHED_WIN_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 Nin=3, Pin=2, window_valid held 1, out_ready=1 -> mux_select sequence 0,1,0,1; window_ready pulses at cycles 2 and 4; out_last=1 on the 2nd and 4th out_valid.
REQ-032 Nin=3, Pin=2, out_ready=0 for 3 cycles after the first issue -> mux_enable=0, mux_select=1 held, out_valid=1 held; resumes with select 1 when out_ready=1.
REQ-033 Nin=Pin=4 (NUM_INPUT=1), 5 windows back-to-back -> 5 consecutive enables; window_ready=1 on every one; out_last is always 1.
REQ-034 Nin=7, Pin=2, rst asserted at grp=2 -> next cycle out_valid=0, grp=0, no window_ready; a new window restarts at select 0.
REQ-035 Nin=3, Pin=2, window_valid dropped after the first group -> the second group is still issued, window_ready pulses, then the FSM enters IDLE.
REQ-036 With MUX_SCHED_WIN_CNT_EN, win_count preloaded to 0xFFFF by forcing 65535 windows -> win_count reads 0 after the next window.
